// File: rtl/mpram_pkg.sv
// mpram_pkg: shared constants and helpers for the LVT multi-ported RAM
package mpram_pkg;
    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int lvt_idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction
endpackage

// File: rtl/mpram_bank.sv
// mpram_bank: 1W1R synchronous-read RAM bank, no reset
module mpram_bank #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    // write port and registered read; read sees the pre-edge contents
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= din;
        dout <= mem[raddr];
    end
endmodule

// File: rtl/lvt_mpram.sv
// lvt_mpram: NUM_WR-write / NUM_RD-read RAM using replicated banks and a live value table
module lvt_mpram
    import mpram_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 4,
    parameter int RD_BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        w_en,
    input  logic [NUM_WR*ADDR_W-1:0] w_addr,
    input  logic [NUM_WR*DATA_W-1:0] w_din,
    input  logic [NUM_RD*ADDR_W-1:0] r_addr,
    output logic [NUM_RD*DATA_W-1:0] r_dout
);
    localparam int IW    = lvt_idx_w(NUM_WR);
    localparam int DEPTH = 1 << ADDR_W;

    logic [IW-1:0]     lvt_idx [DEPTH];
    logic [DEPTH-1:0]  lvt_vld;
    logic [DATA_W-1:0] bank_q [NUM_WR][NUM_RD];
    logic [IW-1:0]     rd_idx [NUM_RD];
    logic [NUM_RD-1:0] rd_vld;
    logic [NUM_RD-1:0] byp_hit;
    logic [DATA_W-1:0] byp_data [NUM_RD];
    logic [NUM_RD-1:0] byp_q;
    logic [DATA_W-1:0] byp_data_q [NUM_RD];

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
            mpram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank (
                .clk   (clk),
                .we    (w_en[w] && !rst),
                .waddr (w_addr[w*ADDR_W +: ADDR_W]),
                .din   (w_din[w*DATA_W +: DATA_W]),
                .raddr (r_addr[r*ADDR_W +: ADDR_W]),
                .dout  (bank_q[w][r])
            );
        end
    end

    // LVT update; later (higher) ports overwrite earlier ones so the highest index wins
    always_ff @(posedge clk) begin
        if (rst) begin
            lvt_vld <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_en[w]) begin
                    lvt_vld[w_addr[w*ADDR_W +: ADDR_W]] <= 1'b1;
                    lvt_idx[w_addr[w*ADDR_W +: ADDR_W]] <= IW'(w);
                end
            end
        end
    end

    // same-cycle write hit per read port, highest enabled writer's data forwarded
    always_comb begin
        byp_hit = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            byp_data[r] = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_en[w] && w_addr[w*ADDR_W +: ADDR_W] == r_addr[r*ADDR_W +: ADDR_W]) begin
                    byp_hit[r]  = 1'b1;
                    byp_data[r] = w_din[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // registered LVT lookup and bypass state, aligned with the bank read
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_RD; r++) begin
            if (rst) begin
                rd_vld[r] <= 1'b0;
                byp_q[r]  <= 1'b0;
            end else begin
                rd_vld[r] <= lvt_vld[r_addr[r*ADDR_W +: ADDR_W]];
                byp_q[r]  <= (RD_BYPASS == RD_NEW) && byp_hit[r];
            end
            rd_idx[r]     <= lvt_idx[r_addr[r*ADDR_W +: ADDR_W]];
            byp_data_q[r] <= byp_data[r];
        end
    end

    // output select: forwarded data, else live bank, else zero for never-written
    always_comb begin
        r_dout = '0;
        for (int r = 0; r < NUM_RD; r++)
            r_dout[r*DATA_W +: DATA_W] = byp_q[r] ? byp_data_q[r] : rd_vld[r] ? bank_q[rd_idx[r]][r] : '0;
    end
endmodule

// File: tb/tb_lvt_mpram.sv
// tb_lvt_mpram: random and directed checks of lvt_mpram in both read modes against a golden array
module tb_lvt_mpram;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int NR = 4;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    w_en;
    logic [NW*AW-1:0] w_addr;
    logic [NW*DW-1:0] w_din;
    logic [NR*AW-1:0] r_addr;
    logic [NR*DW-1:0] dout0;
    logic [NR*DW-1:0] dout1;

    logic [DW-1:0] mem [DEPTH];
    bit            vld [DEPTH];
    logic [DW-1:0] e0 [NR];
    logic [DW-1:0] e1 [NR];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lvt_mpram #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR), .RD_BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_din(w_din), .r_addr(r_addr), .r_dout(dout0)
    );
    lvt_mpram #(.ADDR_W(AW), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR), .RD_BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_din(w_din), .r_addr(r_addr), .r_dout(dout1)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_wr(input int k, input bit en, input int a, input logic [DW-1:0] d);
        w_en[k] = en;
        w_addr[k*AW +: AW] = AW'(a);
        w_din[k*DW +: DW] = d;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        r_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic step();
        for (int r = 0; r < NR; r++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] old, nw;
            bit hit;
            a = r_addr[r*AW +: AW];
            old = vld[a] ? mem[a] : '0;
            hit = 0;
            nw = '0;
            for (int w = 0; w < NW; w++)
                if (w_en[w] && w_addr[w*AW +: AW] == a) begin
                    hit = 1;
                    nw = w_din[w*DW +: DW];
                end
            e0[r] = rst ? '0 : old;
            e1[r] = rst ? '0 : (hit ? nw : old);
        end
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) vld[i] = 0;
        end else begin
            for (int w = 0; w < NW; w++)
                if (w_en[w]) begin
                    mem[w_addr[w*AW +: AW]] = w_din[w*DW +: DW];
                    vld[w_addr[w*AW +: AW]] = 1;
                end
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            check($sformatf("old_p%0d", r), dout0[r*DW +: DW], e0[r]);
            check($sformatf("new_p%0d", r), dout1[r*DW +: DW], e1[r]);
        end
    endtask

    initial begin
        rst = 1'b1;
        w_en = '0;
        w_addr = '0;
        w_din = '0;
        r_addr = '0;
        for (int i = 0; i < DEPTH; i++) vld[i] = 0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        set_rd(0, 5, 2047, 1000);
        step();
        for (int r = 0; r < NR; r++) check("reset_zero", dout0[r*DW +: DW], 32'h0);

        set_wr(0, 1, 5, 32'h11);
        step();
        set_wr(0, 0, 0, 0);
        set_wr(1, 1, 5, 32'h22);
        step();
        set_wr(1, 0, 0, 0);
        set_rd(5, 5, 5, 5);
        step();
        for (int r = 0; r < NR; r++) check("last_writer", dout0[r*DW +: DW], 32'h22);

        set_wr(0, 1, 7, 32'hAA);
        set_wr(1, 1, 7, 32'hBB);
        step();
        set_wr(0, 0, 0, 0);
        set_wr(1, 0, 0, 0);
        set_rd(7, 7, 7, 7);
        step();
        for (int r = 0; r < NR; r++) check("conflict", dout0[r*DW +: DW], 32'hBB);

        set_wr(0, 1, 9, 32'h33);
        step();
        set_wr(0, 1, 9, 32'h44);
        set_rd(9, 9, 9, 9);
        step();
        check("rmw_old", dout0[DW-1:0], 32'h33);
        check("rmw_new", dout1[DW-1:0], 32'h44);
        set_wr(0, 0, 0, 0);
        step();
        check("rmw_after", dout0[DW-1:0], 32'h44);

        set_wr(0, 1, 12, 32'h55);
        step();
        rst = 1'b1;
        set_wr(0, 1, 13, 32'h66);
        step();
        rst = 1'b0;
        set_wr(0, 0, 0, 0);
        set_rd(12, 13, 12, 13);
        step();
        for (int r = 0; r < NR; r++) check("rst_mask", dout0[r*DW +: DW], 32'h0);

        for (int c = 1; c <= 20000 && failures == 0; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int w = 0; w < NW; w++)
                set_wr(w, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH-1),
                       DW'($urandom_range(0, 255)));
            for (int r = 0; r < NR; r++)
                r_addr[r*AW +: AW] = AW'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH-1));
            step();
            if (c % 10000 == 0) $display("progress cycles=%0d checks=%0d", c, checks);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
